// File: rtl/axil_read_width_adapter_if.sv
// ---------------------------------------------------------------------------
// axil_read_width_adapter_if
// Read-only AXI4-Lite channel bundle (AR + R), one instance per side.
//   araddr  [ADDR_W]  read address          (master -> slave)
//   arvalid / arready AR handshake
//   rdata   [DATA_W]  read data              (slave -> master)
//   rresp   [2]       response code          (slave -> master)
//   rvalid  / rready  R handshake
// Modports: master issues requests, slave answers them.
// ---------------------------------------------------------------------------
interface axil_read_width_adapter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_read_width_adapter.sv
// ---------------------------------------------------------------------------
// axil_read_width_adapter
// Read-only AXI4-Lite width down-converter: narrow requester (s_if) to a wide
// memory port (m_if). The AR channel is forwarded combinationally with the
// address aligned to the wide word; the lane each request wants is queued in
// an in-order FIFO so the matching slice of the wide R beat can be returned.
// A flush marks every queued entry as dropped; their responses are then
// accepted from memory and discarded without reaching the requester.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   flush        squash all outstanding requests
//   s_if         narrow side (slave modport), DATA_W = NARROW_W
//   m_if         wide side (master modport),  DATA_W = WIDE_W
//   outstanding  registered in-flight request count
// ---------------------------------------------------------------------------
module axil_read_width_adapter #(
  parameter int ADDR_W          = 64,
  parameter int WIDE_W          = 64,
  parameter int NARROW_W        = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  axil_read_width_adapter_if.slave           s_if,
  axil_read_width_adapter_if.master          m_if,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int RATIO = WIDE_W / NARROW_W;
  localparam int LB    = $clog2(NARROW_W / 8);
  localparam int WB    = $clog2(WIDE_W / 8);
  // Storage widths are kept at least 1 bit; degenerate configs tie them to 0.
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [CW-1:0]     DEPTH      = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]     PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << WB) - ADDR_W'(1));

  // Lane FIFO
  logic [LW-1:0]              r_lane [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_drop;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [CW-1:0]              r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_draining;
  logic [LW-1:0]       w_push_lane;
  logic [LW-1:0]       w_head_lane;
  logic [NARROW_W-1:0] w_rdata;

  assign w_full      = (r_count == DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_head_lane = r_lane[r_rptr];

  // Head response is swallowed if it was squashed earlier, or if a flush is
  // in progress right now (the head is then about to be marked anyway).
  assign w_draining  = !w_empty && (r_drop[r_rptr] || flush);

  // ---------------- lane extraction / data selection ----------------
  generate
    if (RATIO > 1) begin : g_lane
      logic [RATIO-1:0][NARROW_W-1:0] w_words;
      assign w_push_lane = s_if.araddr[WB-1:LB];
      assign w_words     = m_if.rdata;
      assign w_rdata     = w_words[w_head_lane];
    end else begin : g_pass
      assign w_push_lane = '0;
      assign w_rdata     = m_if.rdata;
    end
  endgenerate

  // ---------------- AR path (combinational) ----------------
  // full is the registered count, so a pop in the same cycle does not open
  // a slot until the next cycle.
  assign m_if.araddr  = s_if.araddr & ALIGN_MASK;
  assign m_if.arvalid = rst && s_if.arvalid && !w_full && !flush;
  assign s_if.arready = rst && m_if.arready && !w_full && !flush;
  assign w_push       = s_if.arvalid && s_if.arready;

  // ---------------- R path ----------------
  // A stray beat while empty is neither accepted nor forwarded.
  assign s_if.rvalid  = rst && m_if.rvalid && !w_empty && !w_draining;
  assign m_if.rready  = rst && !w_empty && (w_draining || s_if.rready);
  assign s_if.rdata   = w_rdata;
  assign s_if.rresp   = m_if.rresp;
  assign w_pop        = m_if.rvalid && m_if.rready;

  assign outstanding  = r_count;

  // ---------------- FIFO state ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) begin
        r_drop[r_wptr] <= 1'b0;
        r_wptr         <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      // No push can coincide with flush, so marking everything is safe; the
      // popped slot and empty slots are rewritten on their next push.
      if (flush && !w_empty)
        r_drop <= '1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Lane payload needs no reset: a slot is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (w_push)
      r_lane[r_wptr] <= w_push_lane;
  end

endmodule

// File: tb/tb_axil_read_width_adapter.sv
module tb_axil_read_width_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [2:0] out_a, out_b, out_c;

  always #5 clk = ~clk;

  axil_read_width_adapter_if #(.ADDR_W(64), .DATA_W(32))  ia_s ();
  axil_read_width_adapter_if #(.ADDR_W(64), .DATA_W(64))  ia_m ();
  axil_read_width_adapter_if #(.ADDR_W(64), .DATA_W(16))  ib_s ();
  axil_read_width_adapter_if #(.ADDR_W(64), .DATA_W(128)) ib_m ();
  axil_read_width_adapter_if #(.ADDR_W(64), .DATA_W(64))  ic_s ();
  axil_read_width_adapter_if #(.ADDR_W(64), .DATA_W(64))  ic_m ();

  axil_read_width_adapter #(.ADDR_W(64), .WIDE_W(64), .NARROW_W(32), .MAX_OUTSTANDING(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .s_if(ia_s), .m_if(ia_m), .outstanding(out_a));
  axil_read_width_adapter #(.ADDR_W(64), .WIDE_W(128), .NARROW_W(16), .MAX_OUTSTANDING(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .s_if(ib_s), .m_if(ib_m), .outstanding(out_b));
  axil_read_width_adapter #(.ADDR_W(64), .WIDE_W(64), .NARROW_W(64), .MAX_OUTSTANDING(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .s_if(ic_s), .m_if(ic_m), .outstanding(out_c));

  int n_checks = 0;
  int n_err = 0;

  // scoreboard: aligned addresses awaiting memory data, expected narrow words
  logic [63:0] pend_a[$];
  logic [31:0] exp_q[$];

  function automatic logic [63:0] mem64(input logic [63:0] a);
    if (a == 64'h1000) return 64'hDEADBEEF_01234567;
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  task automatic issue_ar(input logic [63:0] addr);
    logic [63:0] al, d;
    bit done;
    done = 0;
    al = addr & ~64'h7;
    d = mem64(al);
    ia_s.araddr = addr; ia_s.arvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ia_s.arready) begin
        done = 1;
        n_checks++;
        if (ia_m.araddr !== al || ia_m.arvalid !== 1'b1) begin
          n_err++; $display("FAIL ar_fwd addr=%h: m_araddr=%h m_arvalid=%b, want %h 1", addr, ia_m.araddr, ia_m.arvalid, al);
        end
        pend_a.push_back(al);
        exp_q.push_back(addr[2] ? d[63:32] : d[31:0]);
      end
      @(posedge clk); #1;
    end
    ia_s.arvalid = 1'b0;
    if (!done) begin n_checks++; n_err++; $display("FAIL ar_timeout addr=%h: no arready, want accept", addr); end
  endtask

  task automatic respond(input bit vis, input logic [1:0] resp);
    logic [63:0] a;
    logic [31:0] e;
    bit done;
    done = 0;
    if (pend_a.size() == 0) begin n_checks++; n_err++; $display("FAIL respond: nothing pending"); return; end
    a = pend_a.pop_front();
    ia_m.rvalid = 1'b1; ia_m.rdata = mem64(a); ia_m.rresp = resp; ia_s.rready = vis;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ia_m.rready) begin
        done = 1;
        n_checks++;
        if (ia_s.rvalid !== vis) begin n_err++; $display("FAIL r_visible: s_rvalid=%b want %b", ia_s.rvalid, vis); end
        if (vis) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
          n_checks++;
          if (ia_s.rdata !== e || ia_s.rresp !== resp) begin
            n_err++; $display("FAIL r_data: s_rdata=%h s_rresp=%b want %h %b", ia_s.rdata, ia_s.rresp, e, resp);
          end
        end
      end
      @(posedge clk); #1;
    end
    ia_m.rvalid = 1'b0; ia_s.rready = 1'b0; ia_m.rresp = 2'b00;
    if (!done) begin n_checks++; n_err++; $display("FAIL r_timeout: m_rready never high"); end
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    ia_s.arvalid = 1'b1; ia_m.arready = 1'b1; ia_m.rvalid = 1'b1; ia_s.rready = 1'b1;
    #2;
    n_checks++;
    if (out_a !== 3'd0) begin n_err++; $display("FAIL reset_cnt: %0d want 0", out_a); end
    n_checks++;
    if ({ia_s.arready, ia_m.arvalid, ia_s.rvalid, ia_m.rready} !== 4'b0) begin
      n_err++; $display("FAIL reset_outs: %b want 0000", {ia_s.arready, ia_m.arvalid, ia_s.rvalid, ia_m.rready});
    end
    ia_s.arvalid = 1'b0; ia_m.rvalid = 1'b0; ia_s.rready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lane_select;
    issue_ar(64'h1004);
    issue_ar(64'h1000);
    n_checks++;
    if (out_a !== 3'd2) begin n_err++; $display("FAIL lane_cnt: %0d want 2", out_a); end
    respond(1, 2'b00);
    respond(1, 2'b00);
  endtask

  task automatic test_full_stall;
    logic [63:0] a;
    for (int k = 0; k < 4; k++) issue_ar(64'h6000 + 64'(k * 4));
    n_checks++;
    if (out_a !== 3'd4) begin n_err++; $display("FAIL full_cnt: %0d want 4", out_a); end
    ia_s.araddr = 64'h6014; ia_s.arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ia_s.arready !== 1'b0 || ia_m.arvalid !== 1'b0) begin
      n_err++; $display("FAIL full_block: arready=%b m_arvalid=%b want 0 0", ia_s.arready, ia_m.arvalid);
    end
    @(posedge clk); #1;
    a = pend_a.pop_front();
    ia_m.rvalid = 1'b1; ia_m.rdata = mem64(a); ia_s.rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ia_s.arready !== 1'b0 || ia_s.rvalid !== 1'b1 || ia_s.rdata !== exp_q[0]) begin
      n_err++; $display("FAIL full_pop: arready=%b rvalid=%b rdata=%h want 0 1 %h", ia_s.arready, ia_s.rvalid, ia_s.rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    ia_m.rvalid = 1'b0; ia_s.rready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ia_s.arready !== 1'b1 || ia_m.araddr !== 64'h6010) begin
      n_err++; $display("FAIL full_reopen: arready=%b m_araddr=%h want 1 6010", ia_s.arready, ia_m.araddr);
    end
    pend_a.push_back(64'h6010);
    a = mem64(64'h6010);
    exp_q.push_back(a[63:32]);
    @(posedge clk); #1;
    ia_s.arvalid = 1'b0;
    n_checks++;
    if (out_a !== 3'd4) begin n_err++; $display("FAIL full_cnt2: %0d want 4", out_a); end
    for (int k = 0; k < 4; k++) respond(1, 2'b00);
    n_checks++;
    if (out_a !== 3'd0) begin n_err++; $display("FAIL full_drain: %0d want 0", out_a); end
  endtask

  task automatic test_flush;
    issue_ar(64'h7000); issue_ar(64'h7004); issue_ar(64'h7008);
    n_checks++;
    if (out_a !== 3'd3) begin n_err++; $display("FAIL flush_cnt: %0d want 3", out_a); end
    flush = 1'b1; ia_s.araddr = 64'h7010; ia_s.arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ia_s.arready !== 1'b0 || ia_m.arvalid !== 1'b0) begin
      n_err++; $display("FAIL flush_ar_block: arready=%b m_arvalid=%b want 0 0", ia_s.arready, ia_m.arvalid);
    end
    @(posedge clk); #1;
    flush = 1'b0; ia_s.arvalid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) respond(0, 2'b00);
    n_checks++;
    if (out_a !== 3'd0) begin n_err++; $display("FAIL flush_drain: %0d want 0", out_a); end
    issue_ar(64'h2004);
    respond(1, 2'b00);
  endtask

  task automatic test_backpressure;
    logic [63:0] a;
    logic [31:0] e;
    issue_ar(64'h3004);
    a = pend_a.pop_front();
    e = exp_q.pop_front();
    ia_m.rvalid = 1'b1; ia_m.rdata = mem64(a); ia_s.rready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (ia_m.rready !== 1'b0 || ia_s.rvalid !== 1'b1 || ia_s.rdata !== e || out_a !== 3'd1) begin
        n_err++; $display("FAIL bp_hold%0d: m_rready=%b s_rvalid=%b rdata=%h cnt=%0d want 0 1 %h 1", k, ia_m.rready, ia_s.rvalid, ia_s.rdata, out_a, e);
      end
      @(posedge clk); #1;
    end
    ia_s.rready = 1'b1; ia_m.rresp = 2'b10;
    @(negedge clk);
    n_checks++;
    if (ia_m.rready !== 1'b1 || ia_s.rresp !== 2'b10) begin
      n_err++; $display("FAIL bp_release: m_rready=%b rresp=%b want 1 10", ia_m.rready, ia_s.rresp);
    end
    @(posedge clk); #1;
    ia_m.rvalid = 1'b0; ia_s.rready = 1'b0; ia_m.rresp = 2'b00;
    n_checks++;
    if (out_a !== 3'd0) begin n_err++; $display("FAIL bp_single_pop: %0d want 0", out_a); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a;
    logic [31:0] e;
    issue_ar(64'h4000);
    a = pend_a.pop_front();
    e = exp_q.pop_front();
    ia_s.araddr = 64'h4004; ia_s.arvalid = 1'b1;
    ia_m.rvalid = 1'b1; ia_m.rdata = mem64(a); ia_s.rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ia_s.arready !== 1'b1 || ia_s.rvalid !== 1'b1 || ia_s.rdata !== e) begin
      n_err++; $display("FAIL b2b: arready=%b rvalid=%b rdata=%h want 1 1 %h", ia_s.arready, ia_s.rvalid, ia_s.rdata, e);
    end
    pend_a.push_back(64'h4000);
    a = mem64(64'h4000);
    exp_q.push_back(a[63:32]);
    @(posedge clk); #1;
    ia_s.arvalid = 1'b0; ia_m.rvalid = 1'b0; ia_s.rready = 1'b0;
    n_checks++;
    if (out_a !== 3'd1) begin n_err++; $display("FAIL b2b_cnt: %0d want 1", out_a); end
    respond(1, 2'b01);
  endtask

  task automatic test_reset_midflight;
    issue_ar(64'h5000); issue_ar(64'h5004);
    ia_s.arvalid = 1'b1; ia_m.rvalid = 1'b1; ia_s.rready = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_a !== 3'd0 || {ia_s.arready, ia_m.arvalid, ia_s.rvalid, ia_m.rready} !== 4'b0) begin
      n_err++; $display("FAIL rst_mid: cnt=%0d outs=%b want 0 0000", out_a, {ia_s.arready, ia_m.arvalid, ia_s.rvalid, ia_m.rready});
    end
    pend_a.delete(); exp_q.delete();
    ia_s.arvalid = 1'b0; ia_m.rvalid = 1'b0; ia_s.rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue_ar(64'h5004);
    respond(1, 2'b00);
  endtask

  task automatic test_wide128;
    logic [127:0] w;
    logic [15:0] e;
    w = 128'h0F0E0D0C_0B0A0908_07060504_03020100 ^ 128'hA5A5;
    e = w[95:80];
    ib_m.arready = 1'b1; ib_s.araddr = 64'h2A; ib_s.arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ib_m.araddr !== 64'h20 || ib_s.arready !== 1'b1) begin
      n_err++; $display("FAIL w128_ar: m_araddr=%h arready=%b want 20 1", ib_m.araddr, ib_s.arready);
    end
    @(posedge clk); #1;
    ib_s.arvalid = 1'b0;
    ib_m.rvalid = 1'b1; ib_m.rdata = w; ib_s.rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ib_s.rvalid !== 1'b1 || ib_s.rdata !== e) begin
      n_err++; $display("FAIL w128_data: rvalid=%b rdata=%h want 1 %h", ib_s.rvalid, ib_s.rdata, e);
    end
    @(posedge clk); #1;
    ib_m.rvalid = 1'b0; ib_s.rready = 1'b0;
    n_checks++;
    if (out_b !== 3'd0) begin n_err++; $display("FAIL w128_cnt: %0d want 0", out_b); end
  endtask

  task automatic test_ratio1;
    logic [63:0] w;
    w = 64'hFEDCBA98_76543210;
    ic_m.arready = 1'b1; ic_s.araddr = 64'h1234_5677; ic_s.arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ic_m.araddr !== 64'h1234_5670 || ic_s.arready !== 1'b1) begin
      n_err++; $display("FAIL r1_ar: m_araddr=%h arready=%b want 12345670 1", ic_m.araddr, ic_s.arready);
    end
    @(posedge clk); #1;
    ic_s.arvalid = 1'b0;
    ic_m.rvalid = 1'b1; ic_m.rdata = w; ic_s.rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ic_s.rvalid !== 1'b1 || ic_s.rdata !== w) begin
      n_err++; $display("FAIL r1_data: rvalid=%b rdata=%h want 1 %h", ic_s.rvalid, ic_s.rdata, w);
    end
    @(posedge clk); #1;
    ic_m.rvalid = 1'b0; ic_s.rready = 1'b0;
  endtask

  initial begin
    ia_s.araddr = '0; ia_s.arvalid = 0; ia_s.rready = 0;
    ia_m.arready = 0; ia_m.rdata = '0; ia_m.rresp = '0; ia_m.rvalid = 0;
    ib_s.araddr = '0; ib_s.arvalid = 0; ib_s.rready = 0;
    ib_m.arready = 0; ib_m.rdata = '0; ib_m.rresp = '0; ib_m.rvalid = 0;
    ic_s.araddr = '0; ic_s.arvalid = 0; ic_s.rready = 0;
    ic_m.arready = 0; ic_m.rdata = '0; ic_m.rresp = '0; ic_m.rvalid = 0;
    test_reset;
    ia_m.arready = 1'b1;
    test_lane_select;
    test_full_stall;
    test_flush;
    test_backpressure;
    test_back_to_back;
    test_reset_midflight;
    test_wide128;
    test_ratio1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/axil_read_width_adapter.md
Name: axil_read_width_adapter

Overview:
Parametrised read-only AXI4-Lite width down-converter between a narrow requester (e.g. 32-bit instruction fetch) and a wide memory port (e.g. 64-bit cache read channel). It replaces the single-flop lane-select scheme with an in-order lane-tracking FIFO. This allows up to MAX_OUTSTANDING reads in flight, any power-of-two width ratio, and a flush input (branch reset) that silently drains responses to squashed requests.

Parameters:
ADDR_W, 64, address width of both sides
WIDE_W, 64, memory-side data width; power of two, >= NARROW_W
NARROW_W, 32, requester-side data width; power of two, >= 8
MAX_OUTSTANDING, 4, lane-FIFO depth; power of two, >= 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  squash all outstanding requests (branch reset)
s_araddr  in  ADDR_W  narrow read address
s_arvalid  in  1  narrow AR valid
s_arready  out  1  narrow AR ready
s_rdata  out  NARROW_W  selected lane of wide data
s_rresp  out  2  response code, passed through
s_rvalid  out  1  narrow R valid
s_rready  in  1  narrow R ready
m_araddr  out  ADDR_W  wide-aligned address
m_arvalid  out  1  wide AR valid
m_arready  in  1  wide AR ready
m_rdata  in  WIDE_W  wide read data
m_rresp  in  2  wide response code
m_rvalid  in  1  wide R valid
m_rready  out  1  wide R ready
outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight request count

Behaviour:
- Definitions: RATIO=WIDE_W/NARROW_W; LB=$clog2(NARROW_W/8); WB=$clog2(WIDE_W/8).
- Lane = s_araddr[WB-1:LB]. Lane width is 0 when RATIO=1; lane is then fixed at 0 and data passes straight through.
- m_araddr = s_araddr with bits [WB-1:0] cleared.
- State: circular FIFO of {lane, drop}, depth MAX_OUTSTANDING. Write/read pointers wrap modulo depth. outstanding counter is registered.
- full = (outstanding == MAX_OUTSTANDING); empty = (outstanding == 0).
- AR path is combinational, zero added latency:
  - m_arvalid = s_arvalid & !full & !flush
  - s_arready = m_arready & !full & !flush
  - Push {lane, drop=0} on s_arvalid & s_arready.
- R path, head not dropped and flush=0:
  - s_rvalid = m_rvalid & !empty; m_rready = s_rready & !empty
  - s_rdata = m_rdata[lane*NARROW_W +: NARROW_W]; s_rresp = m_rresp
  - Pop on m_rvalid & m_rready.
- R path, head drop=1, or flush=1 and !empty:
  - s_rvalid = 0; m_rready = 1
  - Pop on m_rvalid.
- Flush: at the clock edge of a flush=1 cycle, every entry remaining after that cycle's pop gets drop=1. AR is blocked during flush, so no push can escape marking. Flush while empty has no effect.
- Pointers and counter update once per cycle. outstanding += push - pop:
  - Push and pop in the same cycle: count unchanged.
  - Full with a pop in the same cycle: push is still blocked, because s_arready uses registered full only.
- m_rvalid while empty: m_rready = 0, s_rvalid = 0; the protocol-error response is ignored.
- Reset (rst=0, asynchronous):
  - Pointers, outstanding and all drop bits clear immediately.
  - s_arready, m_arvalid, s_rvalid, m_rready are forced 0 while rst=0.
  - s_rdata and s_rresp are don't-care.
  - Reset mid-operation abandons in-flight requests. The memory side must be reset at the same time.
- Data and response ordering: strictly in-order; AXI4-Lite has no IDs.

Test Plan:
- Lane select, defaults: AR 0x1004 -> m_araddr=0x1000. Return m_rdata=0xDEADBEEF_01234567 -> s_rdata=0xDEADBEEF. AR 0x1000 with the same data -> s_rdata=0x01234567.
- Full stall: m_arready=1, m_rvalid=0, issue 5 ARs -> first 4 accepted, outstanding=4, s_arready=0 on the 5th. One response -> 5th accepted next cycle. All five lanes return in order.
- Flush drain: 3 outstanding, pulse flush for 1 cycle, then return 3 responses -> s_rvalid never asserts, m_rready=1, outstanding 3->0. A following AR to 0x2004 returns the upper word normally.
- Backpressure: s_rready=0 with m_rvalid=1 -> m_rready=0, s_rvalid=1, s_rdata stable. s_rready=1 -> single pop, outstanding decrements by 1.
- Reset mid-flight: 2 outstanding, drive rst=0 asynchronously -> outstanding=0 and all valid/ready outputs 0 before the next clk edge. Release -> normal operation.
- WIDE_W=128, NARROW_W=16: AR 0x2A -> m_araddr=0x20, s_rdata=m_rdata[95:80]. RATIO=1 config: s_rdata==m_rdata, m_araddr cleared to width alignment.
